// File: rtl/dma_pkg.sv
// dma_pkg: shared types and constants for the Unified Buffer DMA engine.
//   dma_state_e : engine FSM states
//   DIR_LOAD    : cmd_dir value for stream -> UB transfers
//   DIR_STORE   : cmd_dir value for UB -> stream transfers
package dma_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    STORE  = 3'd2,
    DRAIN  = 3'd3,
    FINISH = 3'd4
  } dma_state_e;

  localparam logic DIR_LOAD  = 1'b0;
  localparam logic DIR_STORE = 1'b1;

endpackage

// File: rtl/dma_store_fifo.sv
// dma_store_fifo: synchronous DEPTH x DATA_W FIFO for the DMA store path.
//   clk, rst  : clock, asynchronous active-high reset (flushes contents)
//   i_push    : write i_din (ignored when full)
//   i_din     : write data
//   i_pop     : consume head word (ignored when empty)
//   o_dout    : head word (0 after reset)
//   o_empty   : no words held
//   o_count   : number of words held (0..DEPTH)
module dma_store_fifo #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 4,
  localparam int unsigned CW    = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_din,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_dout,
  output logic              o_empty,
  output logic [CW-1:0]     o_count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wptr;
  logic [AW-1:0]     r_rptr;
  logic [CW-1:0]     r_count;
  logic              w_push;
  logic              w_pop;

  assign w_push  = i_push && (r_count != CW'(DEPTH));
  assign w_pop   = i_pop && (r_count != '0);
  assign o_dout  = r_mem[r_rptr];
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= i_din;
        r_wptr        <= r_wptr + AW'(1);
      end
      if (w_pop) r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/dma_engine.sv
// dma_engine: owns the Unified Buffer DMA port; moves cmd_len words between a
// DRAM-side stream and the UB starting at cmd_addr, one word per cycle.
//   clk, reset            : clock, asynchronous active-high reset
//   cmd_valid/cmd_ready   : command handshake (ready only when idle)
//   cmd_dir/addr/len      : 0 = load (stream->UB), 1 = store (UB->stream)
//   in_valid/ready/data   : load stream
//   out_valid/ready/data  : store stream (fed from the store FIFO)
//   ub_write_en/read_en   : UB DMA strobes (never both high)
//   ub_addr/wdata/rdata   : UB DMA address/data (rdata valid cycle after read)
//   busy/done             : transfer in progress / one-cycle completion pulse
module dma_engine
  import dma_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned LEN_W  = 9,
  parameter int unsigned FIFO_D = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_dir,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              ub_write_en,
  output logic              ub_read_en,
  output logic [ADDR_W-1:0] ub_addr,
  output logic [DATA_W-1:0] ub_wdata,
  input  logic [DATA_W-1:0] ub_rdata,
  output logic              busy,
  output logic              done
);

  localparam int unsigned CW = $clog2(FIFO_D) + 1;
  localparam int unsigned OW = CW + 1;

  dma_state_e        r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [LEN_W-1:0]  r_rem;
  logic              r_cmd_ready;
  logic              r_busy;
  logic              r_done;
  logic              r_wr_en;
  logic              r_rd_en;
  logic              r_pend;     // read issued last cycle; ub_rdata valid now
  logic [ADDR_W-1:0] r_ub_addr;
  logic [DATA_W-1:0] r_wdata;

  logic              w_in_fire;
  logic              w_pop;
  logic              w_fifo_empty;
  logic [CW-1:0]     w_fifo_count;
  logic [DATA_W-1:0] w_fifo_dout;
  logic [OW-1:0]     w_occ;
  logic              w_can_read;

  assign in_ready    = (r_state == LOAD) && (r_rem != '0);
  assign w_in_fire   = in_valid && in_ready;
  assign out_valid   = !w_fifo_empty;
  assign out_data    = w_fifo_dout;
  assign w_pop       = out_valid && out_ready;
  assign cmd_ready   = r_cmd_ready;
  assign busy        = r_busy;
  assign done        = r_done;
  assign ub_write_en = r_wr_en;
  assign ub_read_en  = r_rd_en;
  assign ub_addr     = r_ub_addr;
  assign ub_wdata    = r_wdata;

  // Reads are registered one cycle ahead, so the overflow guard projects FIFO
  // occupancy into the next cycle: current words, the word landing this
  // cycle, the read on the port now, minus the word leaving this cycle.
  assign w_occ      = OW'(w_fifo_count) + OW'(r_pend) + OW'(r_rd_en) - OW'(w_pop);
  assign w_can_read = (r_rem != '0) && (w_occ < OW'(FIFO_D));

  dma_store_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_D)
  ) u_fifo (
    .clk     (clk),
    .rst     (reset),
    .i_push  (r_pend),
    .i_din   (ub_rdata),
    .i_pop   (w_pop),
    .o_dout  (w_fifo_dout),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_addr      <= '0;
      r_rem       <= '0;
      r_cmd_ready <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_wr_en     <= 1'b0;
      r_rd_en     <= 1'b0;
      r_pend      <= 1'b0;
      r_ub_addr   <= '0;
      r_wdata     <= '0;
    end else begin
      r_done  <= 1'b0;
      r_wr_en <= 1'b0;
      r_rd_en <= 1'b0;
      r_pend  <= r_rd_en;
      case (r_state)
        IDLE: begin
          if (cmd_valid) begin
            r_cmd_ready <= 1'b0;
            r_addr      <= cmd_addr;
            r_rem       <= cmd_len;
            if (cmd_len == '0) begin
              r_state <= FINISH;
              r_done  <= 1'b1;
            end else begin
              r_busy  <= 1'b1;
              r_state <= (cmd_dir == DIR_STORE) ? STORE : LOAD;
            end
          end
        end
        // LOAD/STORE stay one cycle after the final beat/read so that the
        // registered UB strobe for it is still issued from the active state.
        LOAD: begin
          if (w_in_fire) begin
            r_wr_en   <= 1'b1;
            r_ub_addr <= r_addr;
            r_wdata   <= in_data;
            r_addr    <= r_addr + ADDR_W'(1);
            r_rem     <= r_rem - LEN_W'(1);
          end else if (r_rem == '0) begin
            r_state <= FINISH;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
          end
        end
        STORE: begin
          if (w_can_read) begin
            r_rd_en   <= 1'b1;
            r_ub_addr <= r_addr;
            r_addr    <= r_addr + ADDR_W'(1);
            r_rem     <= r_rem - LEN_W'(1);
          end else if (r_rem == '0) begin
            r_state <= DRAIN;
          end
        end
        DRAIN: begin
          if (w_fifo_empty && !r_pend) begin
            r_state <= FINISH;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
          end
        end
        FINISH: begin
          r_state     <= IDLE;
          r_cmd_ready <= 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_engine.sv
module tb_dma_engine;

  localparam int DW = 16;
  localparam int AW = 8;
  localparam int LW = 9;
  localparam int FD = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid, cmd_ready, cmd_dir;
  logic [AW-1:0] cmd_addr;
  logic [LW-1:0] cmd_len;
  logic          in_valid, in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid, out_ready;
  logic [DW-1:0] out_data;
  logic          ub_write_en, ub_read_en;
  logic [AW-1:0] ub_addr;
  logic [DW-1:0] ub_wdata, ub_rdata;
  logic          busy, done;

  always #5 clk = ~clk;

  dma_engine #(.DATA_W(DW), .ADDR_W(AW), .LEN_W(LW), .FIFO_D(FD)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dir(cmd_dir),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .ub_write_en(ub_write_en), .ub_read_en(ub_read_en), .ub_addr(ub_addr),
    .ub_wdata(ub_wdata), .ub_rdata(ub_rdata),
    .busy(busy), .done(done)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] init_val(int i);
    return DW'((i * 32'h0137) ^ 32'h5A3C);
  endfunction

  // Unified Buffer model: synchronous write, one-cycle read latency.
  logic [DW-1:0] ub_mem [256];
  logic          mem_init;
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) ub_mem[i] <= init_val(i);
    end else if (ub_write_en) begin
      ub_mem[ub_addr] <= ub_wdata;
    end
    if (ub_read_en) ub_rdata <= ub_mem[ub_addr];
  end

  // Reference state: what the UB must contain, and what must appear next.
  logic [DW-1:0] ref_mem [256];
  logic [AW-1:0] exp_wa[$];
  logic [DW-1:0] exp_wd[$];
  logic [DW-1:0] exp_out[$];
  logic [AW-1:0] wr_log[$];
  logic [DW-1:0] out_log[$];
  int            out_cyc_log[$];
  int            done_cnt = 0;
  int            done_cyc = 0;
  int            last_wr_cyc = 0;
  int            rd_iss = 0;
  int            pops = 0;
  bit            quiet = 1'b0;
  bit            prev_stall = 1'b0;
  logic [DW-1:0] prev_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      prev_stall = 1'b0;
      rd_iss = 0;
      pops = 0;
    end else begin
      chk("we_re_exclusive", 32'(ub_write_en && ub_read_en), 0);
      chk("cmd_ready_while_busy", 32'(busy && cmd_ready), 0);
      chk("stream_when_not_busy", 32'((in_ready || out_valid) && !busy), 0);
      if (quiet) begin
        chk("len0_no_ub", 32'(ub_write_en || ub_read_en), 0);
        chk("len0_no_stream", 32'(in_ready || out_valid), 0);
      end
      if (ub_write_en) begin
        if (exp_wa.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_write: got addr %0h data %0h, none expected", ub_addr, ub_wdata);
        end else begin
          logic [AW-1:0] a;
          logic [DW-1:0] d;
          a = exp_wa.pop_front();
          d = exp_wd.pop_front();
          chk("wr_addr", 32'(ub_addr), 32'(a));
          chk("wr_data", 32'(ub_wdata), 32'(d));
          ref_mem[a] = d;
        end
        wr_log.push_back(ub_addr);
        last_wr_cyc = cyc;
      end
      if (ub_read_en) rd_iss++;
      if (out_valid && out_ready) begin
        pops++;
        if (exp_out.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_out: got %0h, none expected", out_data);
        end else begin
          chk("out_data", 32'(out_data), 32'(exp_out.pop_front()));
        end
        out_log.push_back(out_data);
        out_cyc_log.push_back(cyc);
      end
      if (ub_read_en || out_valid) chk("outstanding_le_depth", 32'((rd_iss - pops) <= FD), 1);
      if (prev_stall) begin
        chk("stall_valid_held", 32'(out_valid), 1);
        chk("stall_data_stable", 32'(out_data), 32'(prev_data));
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_cmd_ready"}, 32'(cmd_ready), 1);
    chk({tag, "_in_ready"}, 32'(in_ready), 0);
    chk({tag, "_out_valid"}, 32'(out_valid), 0);
    chk({tag, "_ub_write_en"}, 32'(ub_write_en), 0);
    chk({tag, "_ub_read_en"}, 32'(ub_read_en), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_ub_addr"}, 32'(ub_addr), 0);
    chk({tag, "_ub_wdata"}, 32'(ub_wdata), 0);
    chk({tag, "_out_data"}, 32'(out_data), 0);
  endtask

  // mode: 0 = stream always ready/valid, 1 = out_ready 1,0,0,1, 2 = random.
  // dbase < 0 gives random load data, else dbase+i.
  task automatic run_cmd(input logic dir, input logic [AW-1:0] addr, input int len,
                         input int mode, input int dbase, input bit poke);
    logic [DW-1:0] data[$];
    logic [3:0]    pat;
    int            idx, dc0, c;
    bit            got_done;
    pat = 4'b1001;
    idx = 0;
    got_done = 1'b0;
    data.delete();
    for (int i = 0; i < len; i++) begin
      if (dir == 1'b0) begin
        logic [DW-1:0] d;
        d = (dbase < 0) ? DW'($urandom) : DW'(dbase + i);
        data.push_back(d);
        exp_wa.push_back(AW'(32'(addr) + i));
        exp_wd.push_back(d);
      end else begin
        exp_out.push_back(ref_mem[AW'(32'(addr) + i)]);
      end
    end
    quiet = (len == 0);
    dc0 = done_cnt;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_dir = dir; cmd_addr = addr; cmd_len = LW'(len);
    @(negedge clk);
    chk("cmd_ready_idle", 32'(cmd_ready), 1);
    c = cyc;
    @(posedge clk); #1;
    cmd_valid = poke;
    cmd_dir = ~dir; cmd_addr = ~addr; cmd_len = LW'(7);
    for (int k = 0; k < 3000; k++) begin
      in_valid  = (dir == 1'b0 && mode != 2) ? 1'b1 : 1'($urandom_range(0, 1));
      in_data   = (idx < len) ? data[idx] : 16'hDEAD;
      out_ready = (mode == 0) ? 1'b1 : (mode == 1) ? pat[k % 4] : 1'($urandom_range(0, 1));
      if (k == 4) cmd_valid = 1'b0;
      @(negedge clk);
      if (k == 0) begin
        if (len == 0) chk("len0_done_at_c+1", 32'(done && cyc == c + 1), 1);
        else chk("busy_at_c+1", 32'(busy), 1);
      end
      if (poke && k < 4) chk("cmd_ignored_busy", 32'(cmd_ready), 0);
      if (in_valid && in_ready) idx++;
      if (done) begin
        got_done = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!got_done) begin
      checks++; errors++;
      $display("FAIL done_timeout: got no done, required one (dir %0d len %0d)", dir, len);
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    chk("done_count", 32'(done_cnt - dc0), 1);
    chk("writes_drained", 32'(exp_wa.size()), 0);
    chk("outs_drained", 32'(exp_out.size()), 0);
    if (dir == 1'b0 && len > 0) begin
      chk("beats_taken", 32'(idx), 32'(len));
      chk("done_after_last_write", 32'(done_cyc - last_wr_cyc), 1);
    end
    @(negedge clk);
    chk("done_one_cycle", 32'(done), 0);
    quiet = 1'b0;
    exp_wa.delete(); exp_wd.delete(); exp_out.delete();
  endtask

  logic [AW-1:0] wrap_exp [4];
  int            dc_rst;
  int            nacc;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; mem_init = 1'b1;
    cmd_valid = 1'b0; cmd_dir = 1'b0; cmd_addr = '0; cmd_len = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
    @(posedge clk); @(posedge clk); #1;
    mem_init = 1'b0;
    @(negedge clk);
    chk_reset_vals("por");
    @(posedge clk); #1;
    reset = 1'b0;

    // Load 8 words A0..A7 at 0x00.
    wr_log.delete();
    run_cmd(1'b0, 8'h00, 8, 0, 16'hA0, 1'b0);
    chk("load8_nwrites", 32'(wr_log.size()), 8);
    for (int i = 0; i < 8 && i < wr_log.size(); i++) chk("load8_addr_lit", 32'(wr_log[i]), 32'(i));
    chk("load8_ub_lit", 32'(ub_mem[5]), 32'h00A5);

    // Store them back, out_ready held high: 8 consecutive beats.
    out_log.delete(); out_cyc_log.delete();
    run_cmd(1'b1, 8'h00, 8, 0, -1, 1'b0);
    chk("store8_nbeats", 32'(out_log.size()), 8);
    for (int i = 0; i < 8 && i < out_log.size(); i++) chk("store8_data_lit", 32'(out_log[i]), 32'h00A0 + 32'(i));
    if (out_cyc_log.size() == 8) chk("store8_consecutive", 32'(out_cyc_log[7] - out_cyc_log[0]), 7);

    // Store with out_ready pattern 1,0,0,1.
    out_log.delete();
    run_cmd(1'b1, 8'h00, 8, 1, -1, 1'b0);
    chk("store8bp_nbeats", 32'(out_log.size()), 8);
    for (int i = 0; i < 8 && i < out_log.size(); i++) chk("store8bp_data_lit", 32'(out_log[i]), 32'h00A0 + 32'(i));

    // Address wrap.
    wrap_exp = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    wr_log.delete();
    run_cmd(1'b0, 8'hFE, 4, 0, 16'hB0, 1'b0);
    chk("wrap_nwrites", 32'(wr_log.size()), 4);
    for (int i = 0; i < 4 && i < wr_log.size(); i++) chk("wrap_addr_lit", 32'(wr_log[i]), 32'(wrap_exp[i]));
    chk("wrap_ub_lit", 32'(ub_mem[8'h01]), 32'h00B3);
    run_cmd(1'b1, 8'hFD, 6, 2, -1, 1'b0);

    // Zero-length commands and commands offered while busy.
    run_cmd(1'b0, 8'h10, 0, 0, -1, 1'b0);
    run_cmd(1'b1, 8'h20, 0, 0, -1, 1'b0);
    run_cmd(1'b0, 8'h30, 6, 0, 16'h300, 1'b1);
    run_cmd(1'b1, 8'h30, 6, 2, -1, 1'b1);

    // Reset after 3 of 8 load beats.
    for (int i = 0; i < 8; i++) begin
      exp_wa.push_back(AW'(8'h40 + i));
      exp_wd.push_back(DW'(16'hC0 + i));
    end
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_dir = 1'b0; cmd_addr = 8'h40; cmd_len = LW'(8);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    nacc = 0;
    for (int k = 0; k < 100 && nacc < 3; k++) begin
      in_valid = 1'b1;
      in_data = DW'(16'hC0 + nacc);
      @(negedge clk);
      if (in_valid && in_ready) nacc++;
      if (nacc < 3) begin
        @(posedge clk); #1;
      end
    end
    chk("rst_three_beats", 32'(nacc), 3);
    dc_rst = done_cnt;
    @(posedge clk); #2;
    reset = 1'b1;
    in_valid = 1'b0;
    #1;
    chk_reset_vals("midrst");
    exp_wa.delete(); exp_wd.delete();
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("midrst_no_done", 32'(done_cnt - dc_rst), 0);
    chk("midrst_kept_w0", 32'(ub_mem[8'h40]), 32'h00C0);
    chk("midrst_kept_w1", 32'(ub_mem[8'h41]), 32'h00C1);
    chk("midrst_untouched", 32'(ub_mem[8'h43]), 32'(init_val(8'h43)));
    run_cmd(1'b0, 8'h50, 2, 0, 16'hD0, 1'b0);
    out_log.delete();
    run_cmd(1'b1, 8'h50, 2, 0, -1, 1'b0);
    chk("post_rst_store_n", 32'(out_log.size()), 2);
    if (out_log.size() == 2) chk("post_rst_store_lit", 32'(out_log[1]), 32'h00D1);

    // Randomized traffic.
    for (int n = 0; n < 30; n++) begin
      logic          d;
      logic [AW-1:0] a;
      int            l, m;
      bit            p;
      d = 1'($urandom_range(0, 1));
      a = AW'($urandom_range(0, 255));
      l = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 20);
      m = $urandom_range(0, 2);
      p = (l >= 6) && ($urandom_range(0, 1) == 1);
      run_cmd(d, a, l, m, -1, p);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
